// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block.
//   - pc_sel encodings driven to the fetch stage
//   - mult/div occupancy lengths (cycles)
//   - tuse value meaning "operand not used"
//   - redirect FSM state type
package pipe_ctrl_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_EXC    = 2'b01;
  localparam logic [1:0] PC_EPC    = 2'b10;

  localparam logic [3:0] MULT_CYC  = 4'd5;
  localparam logic [3:0] DIV_CYC   = 4'd10;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Register hazard comparator for one source operand of the instruction in D.
// Ports:
//   src          source register number
//   tuse         cycles until D needs the operand (TUSE_NONE = unused)
//   e_a3/e_tnew  destination and result readiness of the instruction in E
//   m_a3/m_tnew  destination and result readiness of the instruction in M
//   hit          operand depends on a producer whose result is not ready in time
module hazard_cmp (
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  logic [4:0] e_a3,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_a3,
  input  logic [1:0] m_tnew,
  output logic       hit
);

  logic e_hit;
  logic m_hit;

  // Register 0 is never a real destination. TUSE_NONE (3) can never be
  // strictly below a 2-bit tnew, so unused operands never stall.
  assign e_hit = (src == e_a3) && (e_a3 != 5'd0) && (tuse < e_tnew);
  assign m_hit = (src == m_a3) && (m_a3 != 5'd0) && (tuse < m_tnew);
  assign hit   = e_hit || m_hit;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall detection, mult/div occupancy tracking,
// exception/eret redirect and a saturating stall-cycle counter.
// Ports:
//   clk, reset                 clock, async active-low reset
//   d_rs/d_rt, d_tuse_rs/rt    sources of the D instruction and their tuse
//   e_a3/e_tnew, m_a3/m_tnew   producers in E and M
//   d_is_md                    D instruction uses the mult/div unit
//   e_md_start/e_md_div        mult/div start from E (div=1, mult=0)
//   exc_req/eret_req           exception / eret at M
//   f_lock/d_lock/e_clr        stall controls
//   flush, pc_sel              redirect controls
//   md_busy                    mult/div unit occupied
//   stall_cnt                  saturating stall-cycle count
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  e_a3,
  input  logic [4:0]  m_a3,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        d_is_md,
  input  logic        e_md_start,
  input  logic        e_md_div,
  input  logic        exc_req,
  input  logic        eret_req,
  output logic        f_lock,
  output logic        d_lock,
  output logic        e_clr,
  output logic        flush,
  output logic [1:0]  pc_sel,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  state_e      state_q, state_d;
  logic [3:0]  mdcnt_q, mdcnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic rs_hit, rt_hit;
  logic md_hazard, stall;
  logic lock;

  hazard_cmp u_cmp_rs (
    .src    (d_rs),
    .tuse   (d_tuse_rs),
    .e_a3   (e_a3),
    .e_tnew (e_tnew),
    .m_a3   (m_a3),
    .m_tnew (m_tnew),
    .hit    (rs_hit)
  );

  hazard_cmp u_cmp_rt (
    .src    (d_rt),
    .tuse   (d_tuse_rt),
    .e_a3   (e_a3),
    .e_tnew (e_tnew),
    .m_a3   (m_a3),
    .m_tnew (m_tnew),
    .hit    (rt_hit)
  );

  assign md_busy   = (mdcnt_q != 4'd0);
  assign md_hazard = d_is_md && (md_busy || e_md_start);
  assign stall     = rs_hit || rt_hit || md_hazard;

  // Start is only honoured when idle; an exception never aborts the count.
  always_comb begin
    mdcnt_d = mdcnt_q;
    if (e_md_start && (mdcnt_q == 4'd0)) begin
      mdcnt_d = e_md_div ? DIV_CYC : MULT_CYC;
    end else if (mdcnt_q != 4'd0) begin
      mdcnt_d = mdcnt_q - 4'd1;
    end
  end

  // Redirect FSM; flush overrides the stall locks.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    pc_sel  = PC_SEQ;
    lock    = 1'b0;
    case (state_q)
      RUN: begin
        if (exc_req) begin
          flush   = 1'b1;
          pc_sel  = PC_EXC;
          state_d = DRAIN;
        end else if (eret_req) begin
          flush   = 1'b1;
          pc_sel  = PC_EPC;
          state_d = DRAIN;
        end else begin
          lock    = stall;
        end
      end
      DRAIN: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign f_lock = lock;
  assign d_lock = lock;
  assign e_clr  = lock;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (lock && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      mdcnt_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdcnt_q     <= mdcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, e_a3, m_a3;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_div, exc_req, eret_req;
  logic        f_lock, d_lock, e_clr, flush, md_busy;
  logic [1:0]  pc_sel;
  logic [15:0] stall_cnt;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .e_a3       (e_a3),
    .m_a3       (m_a3),
    .e_tnew     (e_tnew),
    .m_tnew     (m_tnew),
    .d_is_md    (d_is_md),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .f_lock     (f_lock),
    .d_lock     (d_lock),
    .e_clr      (e_clr),
    .flush      (flush),
    .pc_sel     (pc_sel),
    .md_busy    (md_busy),
    .stall_cnt  (stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_rs = 5'd0; d_rt = 5'd0; e_a3 = 5'd0; m_a3 = 5'd0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; e_tnew = 2'd0; m_tnew = 2'd0;
    d_is_md = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
    exc_req = 1'b0; eret_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #2;
    n_cmp++; if ({f_lock, d_lock, e_clr, flush} !== 4'b0000) begin
      $display("FAIL reset_ctrl got %b exp 0000", {f_lock, d_lock, e_clr, flush}); n_fail++; end
    n_cmp++; if (pc_sel !== 2'b00) begin
      $display("FAIL reset_pc_sel got %b exp 00", pc_sel); n_fail++; end
    n_cmp++; if (md_busy !== 1'b0) begin
      $display("FAIL reset_md_busy got %b exp 0", md_busy); n_fail++; end
    n_cmp++; if (stall_cnt !== 16'd0) begin
      $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); n_fail++; end
    #1 reset = 1'b1;
  endtask

  task automatic test_load_use();
    tick();
    d_rs = 5'd5; d_tuse_rs = 2'd0; e_a3 = 5'd5; e_tnew = 2'd2;
    #1;
    n_cmp++; if ({f_lock, d_lock, e_clr} !== 3'b111) begin
      $display("FAIL load_use_locks got %b exp 111", {f_lock, d_lock, e_clr}); n_fail++; end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    idle_inputs();
    #1;
    n_cmp++; if (stall_cnt !== exp_cnt) begin
      $display("FAIL load_use_cnt got %0d exp %0d", stall_cnt, exp_cnt); n_fail++; end
    // rt vs M, tuse == tnew: ready in time
    d_rt = 5'd7; d_tuse_rt = 2'd1; m_a3 = 5'd7; m_tnew = 2'd1;
    #1;
    n_cmp++; if (f_lock !== 1'b0) begin
      $display("FAIL rt_m_equal got %b exp 0", f_lock); n_fail++; end
    m_tnew = 2'd2;
    #1;
    n_cmp++; if (f_lock !== 1'b1) begin
      $display("FAIL rt_m_less got %b exp 1", f_lock); n_fail++; end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    idle_inputs();
    #1;
    n_cmp++; if (stall_cnt !== exp_cnt) begin
      $display("FAIL rt_m_cnt got %0d exp %0d", stall_cnt, exp_cnt); n_fail++; end
  endtask

  task automatic test_reg_zero();
    d_rs = 5'd0; d_tuse_rs = 2'd0; e_a3 = 5'd0; e_tnew = 2'd2;
    #1;
    n_cmp++; if (f_lock !== 1'b0) begin
      $display("FAIL reg_zero got %b exp 0", f_lock); n_fail++; end
    d_rs = 5'd9; d_tuse_rs = 2'd3; e_a3 = 5'd9; e_tnew = 2'd3;
    #1;
    n_cmp++; if (f_lock !== 1'b0) begin
      $display("FAIL tuse_none got %b exp 0", f_lock); n_fail++; end
    idle_inputs();
  endtask

  task automatic test_div();
    tick();
    e_md_start = 1'b1; e_md_div = 1'b1; d_is_md = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        tick();
        e_md_start = 1'b0;
      end
      #1;
      n_cmp++; if (md_busy !== ((i >= 1) && (i <= 10))) begin
        $display("FAIL div_busy cyc %0d got %b exp %b", i, md_busy, ((i >= 1) && (i <= 10))); n_fail++; end
      n_cmp++; if (f_lock !== (i <= 10)) begin
        $display("FAIL div_stall cyc %0d got %b exp %b", i, f_lock, (i <= 10)); n_fail++; end
    end
    exp_cnt = exp_cnt + 16'd11;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (stall_cnt !== exp_cnt) begin
      $display("FAIL div_cnt got %0d exp %0d", stall_cnt, exp_cnt); n_fail++; end
  endtask

  task automatic test_mult_restart();
    tick();
    e_md_start = 1'b1; e_md_div = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        tick();
        // a second start while busy must not reload the counter
        e_md_start = (i == 2);
        e_md_div   = (i == 2);
      end
      #1;
      n_cmp++; if (md_busy !== ((i >= 1) && (i <= 5))) begin
        $display("FAIL mult_busy cyc %0d got %b exp %b", i, md_busy, ((i >= 1) && (i <= 5))); n_fail++; end
    end
    n_cmp++; if (f_lock !== 1'b0) begin
      $display("FAIL mult_no_md_stall got %b exp 0", f_lock); n_fail++; end
    idle_inputs();
  endtask

  task automatic test_exc_stall();
    tick();
    d_rs = 5'd5; d_tuse_rs = 2'd0; e_a3 = 5'd5; e_tnew = 2'd2; exc_req = 1'b1;
    #1;
    n_cmp++; if ({flush, pc_sel, f_lock, d_lock, e_clr} !== 6'b101000) begin
      $display("FAIL exc_run got %b exp 101000", {flush, pc_sel, f_lock, d_lock, e_clr}); n_fail++; end
    tick();
    exc_req = 1'b0;
    #1;
    n_cmp++; if ({flush, pc_sel, f_lock, d_lock, e_clr} !== 6'b100000) begin
      $display("FAIL exc_drain got %b exp 100000", {flush, pc_sel, f_lock, d_lock, e_clr}); n_fail++; end
    tick();
    #1;
    n_cmp++; if ({flush, pc_sel, f_lock} !== 4'b0001) begin
      $display("FAIL exc_back_run got %b exp 0001", {flush, pc_sel, f_lock}); n_fail++; end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    idle_inputs();
    #1;
    n_cmp++; if (stall_cnt !== exp_cnt) begin
      $display("FAIL exc_cnt got %0d exp %0d", stall_cnt, exp_cnt); n_fail++; end
  endtask

  task automatic test_both_req();
    exc_req = 1'b1; eret_req = 1'b1;
    #1;
    n_cmp++; if ({flush, pc_sel} !== 3'b101) begin
      $display("FAIL both_prio got %b exp 101", {flush, pc_sel}); n_fail++; end
    tick();
    exc_req = 1'b0;
    #1;
    n_cmp++; if ({flush, pc_sel} !== 3'b100) begin
      $display("FAIL both_drain got %b exp 100", {flush, pc_sel}); n_fail++; end
    tick();
    eret_req = 1'b0;
    #1;
    n_cmp++; if ({flush, pc_sel} !== 3'b000) begin
      $display("FAIL drain_eret_ignored got %b exp 000", {flush, pc_sel}); n_fail++; end
    eret_req = 1'b1;
    #1;
    n_cmp++; if ({flush, pc_sel} !== 3'b110) begin
      $display("FAIL eret_alone got %b exp 110", {flush, pc_sel}); n_fail++; end
    tick();
    eret_req = 1'b0;
    tick();
    #1;
    n_cmp++; if (flush !== 1'b0) begin
      $display("FAIL eret_done got %b exp 0", flush); n_fail++; end
  endtask

  task automatic test_reset_drain();
    tick();
    e_md_start = 1'b1; e_md_div = 1'b1;
    tick();                       // mdcnt 10
    e_md_start = 1'b0;
    tick();                       // 9
    tick();                       // 8
    exc_req = 1'b1;
    tick();                       // 7, DRAIN
    exc_req = 1'b0;
    #1;
    n_cmp++; if ({flush, md_busy} !== 2'b11) begin
      $display("FAIL pre_reset got %b exp 11", {flush, md_busy}); n_fail++; end
    #1 reset = 1'b0;
    #1;
    exp_cnt = 16'd0;
    n_cmp++; if ({md_busy, flush, pc_sel} !== 4'b0000) begin
      $display("FAIL async_reset got %b exp 0000", {md_busy, flush, pc_sel}); n_fail++; end
    n_cmp++; if (stall_cnt !== exp_cnt) begin
      $display("FAIL async_reset_cnt got %0d exp 0", stall_cnt); n_fail++; end
    #1 reset = 1'b1;
    tick();
    tick();
    n_cmp++; if ({md_busy, flush} !== 2'b00) begin
      $display("FAIL post_reset got %b exp 00", {md_busy, flush}); n_fail++; end
  endtask

  task automatic test_saturate();
    tick();
    d_rs = 5'd3; d_tuse_rs = 2'd0; m_a3 = 5'd3; m_tnew = 2'd1;
    repeat (65534) @(posedge clk);
    #1;
    n_cmp++; if (stall_cnt !== 16'hFFFE) begin
      $display("FAIL sat_pre got %h exp fffe", stall_cnt); n_fail++; end
    tick();
    tick();
    tick();
    n_cmp++; if (stall_cnt !== 16'hFFFF) begin
      $display("FAIL sat_hold got %h exp ffff", stall_cnt); n_fail++; end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_div();
    test_mult_restart();
    test_exc_stall();
    test_both_req();
    test_reset_drain();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
 clk  in  1  pipeline clock, rising edge.
 reset  in  1  asynchronous, active-low reset.
 d_rs, d_rt  in  5 each  source registers of the instruction in D.
 d_tuse_rs, d_tuse_rt  in  2 each  cycles until D needs rs/rt; 3 means not used.
 e_a3, m_a3  in  5 each  destination register in E/M; 0 means none.
 e_tnew, m_tnew  in  2 each  cycles until the E/M result is forwardable.
 d_is_md  in  1  instruction in D uses the mult/div unit (HI/LO or start).
 e_md_start  in  1  mult/div start issued from E this cycle.
 e_md_div  in  1  with e_md_start: 1 = div, 0 = mult.
 exc_req  in  1  exception or interrupt taken at M.
 eret_req  in  1  eret reached M.
 f_lock, d_lock  out  1 each  hold the F and D pipeline registers.
 e_clr  out  1  load a bubble into the E register.
 flush  out  1  clear the D, E and M pipeline registers.
 pc_sel  out  2  00 = sequential/branch, 01 = handler 0x4180, 10 = EPC.
 md_busy  out  1  the mult/div unit is occupied.
 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-003 A register hazard SHALL be detected when a source register rs (or rt) matches e_a3 (or m_a3), that destination is nonzero, and the source's tuse is less than the matching tnew.
REQ-004 An MD hazard SHALL be raised when d_is_md=1 and either md_busy=1 or e_md_start=1.
REQ-005 The stall signal SHALL be the OR of the register hazard and the MD hazard; while it is set, f_lock=d_lock=e_clr=1.
REQ-006 mdcnt SHALL be a 4-bit down-counter.
 On e_md_start with mdcnt=0: load 5 for mult, 10 for div.
 Otherwise: decrement while nonzero.
REQ-007 md_busy SHALL equal (mdcnt!=0).
REQ-008 e_md_start while mdcnt!=0 SHALL be ignored (the counter is not reloaded).
REQ-009 The redirect FSM SHALL have states RUN and DRAIN.
 In RUN, exc_req or eret_req SHALL assert flush=1 combinationally, with pc_sel=01 (exception) or 10 (eret), and SHALL move the FSM to DRAIN.
REQ-010 DRAIN SHALL last exactly 1 cycle with flush=1, pc_sel=00 and locks=0, then return to RUN.
 Any exc_req/eret_req seen in DRAIN SHALL be ignored.
REQ-011 Priority SHALL be exc_req > eret_req > stall.
 When flush=1, f_lock, d_lock and e_clr SHALL all be 0.
REQ-012 An exception SHALL NOT abort mdcnt; a busy mult/div runs to completion.
REQ-013 stall_cnt SHALL increment on every cycle in which f_lock=1, and SHALL saturate at 0xFFFF.
REQ-014 All outputs except the registered mdcnt, state and stall_cnt SHALL be combinational from the inputs and those registers; the block adds no extra latency.

Reset
REQ-015 When reset=0, the block SHALL immediately set state=RUN, mdcnt=0 and stall_cnt=0.
 As a result, md_busy=0 and pc_sel=00.
 flush and the locks then depend only on the inputs.
REQ-016 A reset asserted mid-operation (mult/div busy, or in DRAIN) SHALL abandon that operation without further pulses.

Structure
REQ-017 A shared package SHALL hold:
 pc_sel encodings (PC_SEQ=00, PC_EXC=01, PC_EPC=10);
 MULT_CYC=5 and DIV_CYC=10;
 TUSE_NONE=3;
 the state enum {RUN, DRAIN}.
REQ-018 Hazard comparison SHALL be a sub-module, hazard_cmp, instantiated once per source (rs, rt).
 It takes (src, tuse, e_a3, e_tnew, m_a3, m_tnew) and outputs hit.

Verification
REQ-019 Load-use: set d_rs=5, d_tuse_rs=0, e_a3=5, e_tnew=2 -> f_lock=d_lock=e_clr=1; stall_cnt increments by 1.
REQ-020 Register $0: set d_rs=0, d_tuse_rs=0, e_a3=0, e_tnew=2 -> no stall.
REQ-021 Div with a following mfhi: pulse e_md_start with e_md_div=1, then hold d_is_md=1 -> md_busy=1 for 10 cycles and stall for 11 cycles, including the start cycle.
REQ-022 Exception during stall: assert exc_req while a load-use hazard is active -> flush=1, pc_sel=01, locks=0; the next cycle flush=1, pc_sel=00; then RUN.
REQ-023 Both requests: assert exc_req and eret_req in the same cycle -> pc_sel=01. Then assert eret_req alone in the DRAIN cycle -> it is ignored.
REQ-024 Reset in DRAIN with mdcnt=7: drive reset=0 asynchronously -> md_busy=0, flush=0 and state=RUN before the next clock edge.
